// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and encodings for the add/sub scheduler.
// Imported by the arbiter, the interface and the scheduler top.
package fp_sched_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/fp_addsub_sched_if.sv
// Bundle of requester, shared-unit and response signals.
// master is the scheduler side, slave is the surrounding system.
interface fp_addsub_sched_if;
  import fp_sched_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_op;

  logic [DATA_W-1:0] au_a;
  logic [DATA_W-1:0] au_b;
  logic              au_sign;
  logic [DATA_W-1:0] au_result;
  logic              au_exception;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_id;
  logic              resp_exception;
  logic              busy;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  au_result, au_exception, resp_ready,
    output req0_ready, req1_ready,
    output au_a, au_b, au_sign,
    output resp_valid, resp_result, resp_id,
    output resp_exception, busy
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output au_result, au_exception, resp_ready,
    input  req0_ready, req1_ready,
    input  au_a, au_b, au_sign,
    input  resp_valid, resp_result, resp_id,
    input  resp_exception, busy
  );

endinterface

// File: rtl/fp_addsub_sched_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// ptr names the requester that wins a tie.
module rr_arb2
  import fp_sched_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       winner
);

  assign grant[0] = valid[0] & (~valid[1] | (ptr == REQ0));
  assign grant[1] = valid[1] & (~valid[0] | (ptr == REQ1));
  assign winner   = grant[1] ? REQ1 : REQ0;

endmodule

// File: rtl/fp_addsub_sched.sv
// Shares one combinational add/sub unit between two requesters,
// one operation in flight, result returned on a valid/ready channel.
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int W          = 32
) (
  input logic                clk,
  input logic                rst,
  fp_addsub_sched_if.master  bus
);

  state_t         state;
  logic [3:0]     cnt;
  logic           rr_ptr;
  logic           id_reg;
  logic [1:0]     grant;
  logic           winner;
  logic           idle;
  logic           take;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           op_sel;

  logic [W-1:0]   au_a_q;
  logic [W-1:0]   au_b_q;
  logic           au_sign_q;
  logic           resp_valid_q;
  logic [W-1:0]   resp_result_q;
  logic           resp_id_q;
  logic           resp_exc_q;
  logic           busy_q;

  rr_arb2 u_arb (
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign idle           = (state == IDLE);
  assign take           = idle & (|grant);
  assign bus.req0_ready = idle & grant[0];
  assign bus.req1_ready = idle & grant[1];

  assign a_sel  = winner ? bus.req1_a  : bus.req0_a;
  assign b_sel  = winner ? bus.req1_b  : bus.req0_b;
  assign op_sel = winner ? bus.req1_op : bus.req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= REQ0;
      id_reg        <= REQ0;
      au_a_q        <= '0;
      au_b_q        <= '0;
      au_sign_q     <= OP_ADD;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= REQ0;
      resp_exc_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            au_a_q    <= a_sel;
            au_b_q    <= b_sel;
            au_sign_q <= op_sel;
            id_reg    <= winner;
            rr_ptr    <= ~winner;
            cnt       <= 4'(SETTLE_CYC - 1);
            state     <= ISSUE;
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          // Operands have settled on the unit once cnt runs out.
          if (cnt == 4'd0) begin
            resp_result_q <= bus.au_result;
            resp_exc_q    <= bus.au_exception;
            resp_id_q     <= id_reg;
            resp_valid_q  <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.au_a           = au_a_q;
  assign bus.au_b           = au_b_q;
  assign bus.au_sign        = au_sign_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_result    = resp_result_q;
  assign bus.resp_id        = resp_id_q;
  assign bus.resp_exception = resp_exc_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for the add/sub scheduler with a stand-in shared unit.
// Directed cases first, then randomized traffic against a scoreboard.
module tb_fp_addsub_sched;

  localparam int SC = 2;
  localparam logic [31:0] P_INF = 32'h7F80_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_addsub_sched_if bus ();

  fp_addsub_sched #(.SETTLE_CYC(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit mdl_ptr = 1'b0;

  function automatic logic [32:0] unit_fn(
    input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == P_INF || b == P_INF)
      return {1'b1, 32'hFFFF_FFFF};
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s)
      return {1'b0, 32'h4040_0000};
    if (a == 32'h40A0_0000 && b == 32'h4040_0000 && s)
      return {1'b0, 32'h4000_0000};
    if (a == b && s)
      return 33'd0;
    return {1'b0, a ^ {b[15:0], b[31:16]} ^ {32{s}}};
  endfunction

  always_comb begin
    {bus.au_exception, bus.au_result} =
      unit_fn(bus.au_a, bus.au_b, bus.au_sign);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input bit v0, input logic [31:0] a0, input logic [31:0] b0,
    input bit o0,
    input bit v1, input logic [31:0] a1, input logic [31:0] b1,
    input bit o1,
    input int bp);
    bit w;
    logic [31:0] ea, eb;
    logic eo;
    logic [32:0] er;
    int lat;
    bit seen;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req0_valid = v0; bus.req0_a = a0;
    bus.req0_b = b0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_a = a1;
    bus.req1_b = b1; bus.req1_op = o1;
    w  = (v0 && v1) ? mdl_ptr : v1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? o1 : o0;
    er = unit_fn(ea, eb, eo);
    #1;
    check("rdy0", 32'(bus.req0_ready), 32'(!w));
    check("rdy1", 32'(bus.req1_ready), 32'(w));
    @(posedge clk);
    mdl_ptr = ~w;
    #1;
    bus.req0_a = $urandom; bus.req0_b = $urandom;
    bus.req1_a = $urandom; bus.req1_b = $urandom;
    bus.req0_op = ~o0; bus.req1_op = ~o1;
    check("busy_iss", 32'(bus.busy), 32'd1);
    check("rdy_iss", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      lat++;
      if (i == 0) lat = 0;
      if (bus.resp_valid) seen = 1'b1;
    end
    check("latency", 32'(lat), 32'(SC));
    check("result", bus.resp_result, er[31:0]);
    check("id", 32'(bus.resp_id), 32'(w));
    check("exc", 32'(bus.resp_exception), 32'(er[32]));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_result", bus.resp_result, er[31:0]);
      check("bp_rdy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drop_valid", 32'(bus.resp_valid), 32'd0);
    check("drop_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit bad;
    bus.req0_valid = 1'b0; bus.req0_a = '0;
    bus.req0_b = '0; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0;
    bus.req1_b = '0; bus.req1_op = 1'b0;
    bus.resp_ready = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_au_a", bus.au_a, 32'd0);
    check("rst_result", bus.resp_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 4; k++)
      run_op(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0,
             1'b1, 32'h40A0_0000, 32'h4040_0000, 1'b1, 0);

    run_op(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0,
           1'b0, 32'h0, 32'h0, 1'b0, 0);
    check("add_val", bus.resp_result, 32'h4040_0000);
    run_op(1'b0, 32'h0, 32'h0, 1'b0,
           1'b1, 32'h40A0_0000, 32'h4040_0000, 1'b1, 0);
    check("sub_val", bus.resp_result, 32'h4000_0000);

    run_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0,
           1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 10);
    run_op(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0,
           1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1, 0);

    run_op(1'b1, P_INF, 32'h3F80_0000, 1'b0,
           1'b0, 32'h0, 32'h0, 1'b0, 1);

    for (int k = 0; k < 20; k++) begin
      int v;
      logic [31:0] ra0, rb0, ra1, rb1;
      v = $urandom_range(1, 3);
      ra0 = $urandom; rb0 = $urandom;
      ra1 = $urandom; rb1 = $urandom;
      if ($urandom_range(0, 3) == 0) rb0 = ra0;
      if ($urandom_range(0, 5) == 0) ra1 = P_INF;
      run_op(v[0], ra0, rb0, 1'($urandom),
             v[1], ra1, rb1, 1'($urandom), $urandom_range(0, 3));
    end

    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h3F80_0000;
    bus.req0_b = 32'h4000_0000; bus.req0_op = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h40A0_0000;
    bus.req1_b = 32'h4040_0000; bus.req1_op = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_valid", 32'(bus.resp_valid), 32'd0);
    check("mrst_au_a", bus.au_a, 32'd0);
    check("mrst_au_b", bus.au_b, 32'd0);
    check("mrst_sign", 32'(bus.au_sign), 32'd0);
    check("mrst_result", bus.resp_result, 32'd0);
    check("mrst_id", 32'(bus.resp_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mdl_ptr = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.busy) bad = 1'b1;
    end
    check("mrst_noresp", 32'(bad), 32'd0);
    run_op(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b0,
           1'b1, 32'h40A0_0000, 32'h4040_0000, 1'b1, 0);
    check("mrst_grant0", 32'(bus.resp_id), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fp_addsub_sched.md
Name: fp_addsub_sched

Overview:
- Two-requester scheduler that shares one combinational 32-bit IEEE-754 add/sub unit between two clients.
- Arbitrates round-robin and registers the winner's operands and op onto the unit's inputs.
- Waits a fixed settle time, then captures result and exception into a response register.
- Returns the response with the requester ID on a valid/ready channel. One operation is in flight at a time.

Parameters:
- SETTLE_CYC, 2: cycles operands are held on the unit before the result is sampled. Legal range 1..15.
- W, 32: operand/result width. Fixed at 32, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  32  operand A
- req0_b  in  32  operand B
- req0_op  in  1  0=add, 1=subtract (A-B)
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1
- au_a  out  32  to shared unit input A (registered)
- au_b  out  32  to shared unit input B (registered)
- au_sign  out  1  to shared unit add/sub select (registered)
- au_result  in  32  from shared unit
- au_exception  in  1  from shared unit
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_result  out  32  captured result
- resp_id  out  1  requester that issued the operation
- resp_exception  out  1  captured exception flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (on rst, immediately and asynchronously):
  - state=IDLE, rr_ptr=0, counter=0
  - au_a=0, au_b=0, au_sign=0
  - resp_valid=0, resp_result=0, resp_id=0, resp_exception=0, busy=0
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant is combinational from req*_valid and rr_ptr.
  - If only one requester is valid, it wins. If both are valid, requester rr_ptr wins.
  - reqN_ready=1 only for the winner, only in IDLE; both readies are 0 in every other state.
  - On an accepting edge (valid & ready):
    - au_a/au_b/au_sign <= winner's a/b/op
    - id_reg <= winner
    - rr_ptr <= ~winner
    - counter <= SETTLE_CYC-1
    - state <= ISSUE
  - With no valid request, rr_ptr is unchanged.
- ISSUE:
  - au_* are held stable. counter decrements each cycle.
  - When counter==0:
    - resp_result <= au_result
    - resp_exception <= au_exception
    - resp_id <= id_reg
    - resp_valid <= 1
    - state <= RESP
- RESP:
  - resp_* are held stable while resp_valid=1 and resp_ready=0. Backpressure is unbounded.
  - On resp_ready=1: resp_valid <= 0, state <= IDLE.
  - No acceptance in the same cycle, so back-to-back throughput is one op per SETTLE_CYC+2 cycles minimum.
- Latency: resp_valid rises SETTLE_CYC edges after the accepting edge.
- au_* keep their last values after an operation; they are not cleared in IDLE.
- No arithmetic is done here. Results pass through bit-exact, including the 0xFFFFFFFF exception encoding and zero results.
- Reset in ISSUE or RESP:
  - The operation is dropped and no response is produced.
  - Requesters must re-issue.
- Request inputs are sampled only on the accepting edge. Changes while the request is not ready have no effect.

Decomposition:
- Package fp_sched_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2)
  - OP_ADD=1'b0, OP_SUB=1'b1
  - REQ0=1'b0, REQ1=1'b1
- One sub-module rr_arb2: inputs valid[1:0] and ptr; outputs one-hot grant[1:0] and winner. Purely combinational, instantiated once.
- The shared add/sub unit is instantiated by the parent, not inside this block.

Test Plan:
- Add: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0, resp_ready=1 -> resp_result=0x40400000 (3.0), resp_id=0, resp_exception=0, resp_valid exactly SETTLE_CYC edges after acceptance.
- Subtract: req1 a=0x40A00000 (5.0), b=0x40400000 (3.0), op=1 -> resp_result=0x40000000 (2.0), resp_id=1.
- Contention: both valid from reset with different operand pairs, held valid -> grants alternate 0,1,0,1 over four operations. resp_id sequence matches, and each result is correct for its requester.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_* stable, both readies 0, busy=1. Raise resp_ready -> resp_valid drops next edge, and a pending request is accepted on the following edge.
- Exception: a=0x7F800000, b=0x3F800000, op=0 -> resp_exception=1, resp_result=0xFFFFFFFF.
- Reset mid-operation: assert rst during ISSUE -> all outputs at reset values immediately and no response afterwards. The next request after release is granted to requester 0 when both are valid.
